// File: rtl/hc165_reader_pkg.sv
// Shared constants and FSM encoding for the 74HC165 reader and its 74HC595 sibling.
// Pure declarations; no logic, latency or backpressure.
package hc_pkg;

  localparam int unsigned HC_DATA_WIDTH = 16;
  localparam int unsigned HC_CLK_DIV    = 25;
  localparam int unsigned HC_SCAN_TICKS = 2000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_DONE,
    ST_WAIT
  } hc_state_e;

endpackage

// File: rtl/hc165_reader_if.sv
// Host-side bus of the 165 reader: scan enable in, frame word / valid pulse / busy out.
// No backpressure; the consumer must take data on the data_valid pulse or read the held word.
interface hc165_reader_if import hc_pkg::*; #(
  parameter int unsigned DATA_WIDTH = HC_DATA_WIDTH
);
  logic                  r_en;
  logic [DATA_WIDTH-1:0] data;
  logic                  data_valid;
  logic                  busy;

  modport master (input r_en, output data, data_valid, busy);
  modport slave  (output r_en, input data, data_valid, busy);
endinterface

// File: rtl/hc165_reader_tick_gen.sv
// Half-bit tick divider: one-clk tick every CLK_DIV clocks while run is high.
// Count is held at zero while run is low so the first tick lands a full period after run rises.
module hc_tick_gen #(
  parameter int unsigned CLK_DIV = 25
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic tick
);
  localparam int unsigned   CW   = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!run || cnt_q == LAST) cnt_d = '0;
    else                       cnt_d = cnt_q + 1'b1;
  end

  assign tick = run && (cnt_q == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
endmodule

// File: rtl/hc165_reader.sv
// Periodic reader for a daisy-chained 74HC165 chain; frame = (2+2*DATA_WIDTH) ticks + 1 clk.
// No backpressure: each completed frame overwrites data and pulses data_valid for one clk.
module hc165_reader import hc_pkg::*; #(
  parameter int unsigned DATA_WIDTH = HC_DATA_WIDTH,
  parameter int unsigned CLK_DIV    = HC_CLK_DIV,
  parameter int unsigned SCAN_TICKS = HC_SCAN_TICKS
) (
  input  logic              clk,
  input  logic              reset_n,
  hc165_reader_if.master    bus,
  output logic              sh_ld,
  output logic              sck,
  input  logic              qh
);
  localparam int unsigned   BW        = $clog2(DATA_WIDTH + 1);
  localparam int unsigned   SW        = $clog2(SCAN_TICKS + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_TICKS - 1);

  hc_state_e             state_q, state_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [SW-1:0]         scan_q, scan_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  dv_q, dv_d;
  logic                  sh_ld_q, sck_q, busy_q;
  logic [1:0]            qh_sync_q;
  logic                  qh_s;
  logic                  tick;
  logic                  run;

  assign run  = (state_q != ST_IDLE) || bus.r_en;
  assign qh_s = qh_sync_q[1];

  hc_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (run),
    .tick    (tick)
  );

  // scan_q counts ticks since LOAD entry; it also times the 2-tick LOAD phase.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    scan_d    = scan_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    if (tick && state_q != ST_IDLE) scan_d = scan_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        scan_d    = '0;
        bit_cnt_d = '0;
        if (tick && bus.r_en) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (tick && scan_q == SW'(1)) begin
          state_d   = ST_SHIFT_LO;
          bit_cnt_d = '0;
        end
      end
      ST_SHIFT_LO: begin
        if (tick) begin
          shreg_d = {shreg_q[DATA_WIDTH-2:0], qh_s};
          state_d = ST_SHIFT_HI;
        end
      end
      ST_SHIFT_HI: begin
        if (tick) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          state_d   = (bit_cnt_q == BIT_LAST) ? ST_DONE : ST_SHIFT_LO;
        end
      end
      ST_DONE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (tick && scan_q >= SCAN_LAST) begin
          state_d = bus.r_en ? ST_LOAD : ST_IDLE;
          scan_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Outputs are registered from the next state so they line up with state_q.
    dv_d = (state_d == ST_DONE);
    if (dv_d) data_d = shreg_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      scan_q    <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      dv_q      <= 1'b0;
      sh_ld_q   <= 1'b1;
      sck_q     <= 1'b0;
      busy_q    <= 1'b0;
      qh_sync_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      scan_q    <= scan_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      dv_q      <= dv_d;
      sh_ld_q   <= (state_d != ST_LOAD);
      sck_q     <= (state_d == ST_SHIFT_HI);
      busy_q    <= (state_d inside {ST_LOAD, ST_SHIFT_LO, ST_SHIFT_HI, ST_DONE});
      qh_sync_q <= {qh_sync_q[0], qh};
    end
  end

  assign sh_ld          = sh_ld_q;
  assign sck            = sck_q;
  assign bus.data       = data_q;
  assign bus.data_valid = dv_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_hc165_reader.sv
// Bench for hc165_reader against a behavioural two-chip 74HC165 chain and pin-level monitors.
module tb_hc165_reader;
  import hc_pkg::*;

  localparam int W      = 16;
  localparam int DIV    = 25;
  localparam int SCAN   = 40;
  localparam int PERIOD = SCAN * DIV;
  localparam int TMO    = 2 * PERIOD + 2000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sh_ld, sck, qh;
  logic [15:0] par_in = 16'h0000;
  logic [15:0] chain_sr = 16'h0000;

  hc165_reader_if #(.DATA_WIDTH(W)) bus ();

  hc165_reader #(.DATA_WIDTH(W), .CLK_DIV(DIV), .SCAN_TICKS(SCAN)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master),
    .sh_ld   (sh_ld),
    .sck     (sck),
    .qh      (qh)
  );

  always #10 clk = ~clk;

  // Two cascaded 165s: PL loads asynchronously, CP rise shifts toward QH of the last chip.
  always @(posedge sck or negedge sh_ld) begin
    if (!sh_ld) chain_sr <= par_in;
    else        chain_sr <= {chain_sr[14:0], 1'b0};
  end
  assign qh = chain_sr[15];

  int cyc, rise_cnt, last_rises, low_len, last_low_len, last_load_cyc, load_spacing;
  int loads_total, rises_total, busy_cyc, dv_high, dv_pulses, sck_in_load, data_glitch;
  logic prev_sck = 1'b0, prev_shld = 1'b1, prev_dv = 1'b0;
  logic [15:0] prev_data = 16'h0000;

  always @(negedge clk) begin
    cyc       <= cyc + 1;
    prev_sck  <= sck;
    prev_shld <= sh_ld;
    prev_dv   <= bus.data_valid;
    prev_data <= bus.data;
    if (sck && !prev_sck) begin
      rise_cnt    <= rise_cnt + 1;
      rises_total <= rises_total + 1;
    end
    if (!sh_ld && prev_shld) begin
      rise_cnt      <= 0;
      low_len       <= 1;
      load_spacing  <= cyc - last_load_cyc;
      last_load_cyc <= cyc;
      loads_total   <= loads_total + 1;
    end else if (!sh_ld) begin
      low_len <= low_len + 1;
    end
    if (sh_ld && !prev_shld) last_low_len <= low_len;
    if (!sh_ld && sck) sck_in_load <= sck_in_load + 1;
    if (bus.busy) busy_cyc <= busy_cyc + 1;
    if (bus.data_valid) dv_high <= dv_high + 1;
    if (bus.data_valid && !prev_dv) begin
      dv_pulses  <= dv_pulses + 1;
      last_rises <= rise_cnt;
    end
    if (reset_n && bus.data != prev_data && !bus.data_valid) data_glitch <= data_glitch + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_dv(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk); #1;
      if (bus.data_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_load(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk); #1;
      if (!sh_ld) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_rises(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk); #1;
      if (rise_cnt >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic frame_check(input string tag, input logic [15:0] exp, input bit chk_spacing);
    bit ok;
    wait_dv(ok);
    check({tag, " dv seen"}, 32'(ok), 1);
    check({tag, " data"}, 32'(bus.data), 32'(exp));
    check({tag, " sck rises"}, last_rises, W);
    check({tag, " pl low clk"}, last_low_len, 2 * DIV);
    if (chk_spacing) check({tag, " load spacing"}, load_spacing, PERIOD);
    @(negedge clk); #1;
    check({tag, " busy after"}, 32'(bus.busy), 0);
    check({tag, " dv width"}, 32'(bus.data_valid), 0);
  endtask

  typedef struct packed {
    logic [15:0] par;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    bit ok;
    int l0, r0;
    logic [15:0] rnd;

    vecs[0] = '{par: 16'hA55A, exp: 16'hA55A};
    vecs[1] = '{par: 16'h0001, exp: 16'h0001};
    vecs[2] = '{par: 16'h8000, exp: 16'h8000};
    vecs[3] = '{par: 16'h0000, exp: 16'h0000};
    vecs[4] = '{par: 16'hFFFF, exp: 16'hFFFF};
    vecs[5] = '{par: 16'h3C96, exp: 16'h3C96};

    bus.r_en = 1'b0;
    reset_n  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst sh_ld", 32'(sh_ld), 1);
    check("rst sck", 32'(sck), 0);
    check("rst data", 32'(bus.data), 0);
    check("rst dv", 32'(bus.data_valid), 0);
    check("rst busy", 32'(bus.busy), 0);

    reset_n = 1'b1;
    repeat (1000) @(negedge clk);
    #1;
    check("idle loads", loads_total, 0);
    check("idle rises", rises_total, 0);
    check("idle busy", busy_cyc, 0);

    for (int i = 0; i < 6; i++) begin
      par_in = vecs[i].par;
      if (i == 0) bus.r_en = 1'b1;
      frame_check($sformatf("vec%0d", i), vecs[i].exp, i > 0);
    end

    for (int i = 0; i < 6; i++) begin
      rnd = 16'($urandom);
      par_in = rnd;
      frame_check($sformatf("rnd%0d", i), rnd, 1'b1);
    end

    // Brief r_en drop inside WAIT must not disturb the schedule or add a frame.
    repeat (20) @(negedge clk);
    bus.r_en = 1'b0;
    repeat (40) @(negedge clk);
    bus.r_en = 1'b1;
    l0 = loads_total;
    par_in = 16'h5AA5;
    frame_check("reen", 16'h5AA5, 1'b1);
    check("reen one load", loads_total, l0 + 1);

    par_in = 16'hFFFF;
    wait_load(ok);
    check("dis load seen", 32'(ok), 1);
    wait_rises(5, ok);
    check("dis bit5 seen", 32'(ok), 1);
    bus.r_en = 1'b0;
    frame_check("dis", 16'hFFFF, 1'b1);
    l0 = loads_total;
    r0 = rises_total;
    repeat (PERIOD + 200) @(negedge clk);
    #1;
    check("dis no load", loads_total, l0);
    check("dis no sck", rises_total, r0);
    check("dis busy", 32'(bus.busy), 0);
    check("dis sh_ld", 32'(sh_ld), 1);
    check("dis data held", 32'(bus.data), 32'hFFFF);

    par_in = 16'hC3C3;
    bus.r_en = 1'b1;
    wait_load(ok);
    check("rstmid load seen", 32'(ok), 1);
    wait_rises(8, ok);
    check("rstmid bit8 seen", 32'(ok), 1);
    reset_n = 1'b0;
    #1;
    check("rstmid sh_ld", 32'(sh_ld), 1);
    check("rstmid sck", 32'(sck), 0);
    check("rstmid data", 32'(bus.data), 0);
    check("rstmid dv", 32'(bus.data_valid), 0);
    check("rstmid busy", 32'(bus.busy), 0);
    repeat (3) @(negedge clk);
    par_in  = 16'h1234;
    reset_n = 1'b1;
    frame_check("postrst", 16'h1234, 1'b0);

    check("sck during pl", sck_in_load, 0);
    check("dv pulse width", dv_high, dv_pulses);
    check("data only on dv", data_glitch, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
